// File: rtl/quantum_scheduler.sv
// quantum_scheduler: round-robin preemption controller over PROC_N process slots with timed I/O blocking.
// Optional QUANTUM_SCHEDULER_STATS_EN adds saturating switch/preempt counters.
module quantum_scheduler #(
   parameter int PC_W        = 32,
   parameter int PROC_N      = 4,
   parameter int QUANTUM_DEF = 10,
   parameter int OS_PC_LIMIT = 300,
   parameter int IO_LAT      = 8,
   localparam int PID_W      = $clog2(PROC_N)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [PC_W-1:0]  pc,
   input  logic             instr_valid,
   input  logic             io_instr,
   input  logic             proc_end,
   input  logic             proc_start,
   input  logic [PID_W-1:0] start_pid,
   input  logic [PC_W-1:0]  start_pc,
   input  logic             quantum_load,
   input  logic [15:0]      quantum_val,
   input  logic             switch_ack,
   output logic             switch_req,
   output logic [1:0]       switch_cause,
   output logic [PID_W-1:0] next_pid,
   output logic [PC_W-1:0]  next_pc,
   output logic [PID_W-1:0] cur_pid,
   output logic             idle
`ifdef QUANTUM_SCHEDULER_STATS_EN
   ,output logic [31:0]     switch_cnt,
   output logic [31:0]      preempt_cnt
`endif
);
   localparam int BW = $clog2(IO_LAT + 1);
   localparam logic [1:0] S_EMPTY = 2'd0, S_READY = 2'd1, S_RUN = 2'd2, S_BLOCKED = 2'd3;
   localparam logic [1:0] F_IDLE = 2'd0, F_RUN = 2'd1, F_SWITCH = 2'd2;

   logic [1:0]       slot_state [PROC_N];
   logic [PC_W-1:0]  saved_pc   [PROC_N];
   logic [BW-1:0]    blk_cnt    [PROC_N];
   logic [1:0]       fsm;
   logic [15:0]      count, quantum;
   logic [PID_W-1:0] sel, idx;
   logic             found, active, ev_end, ev_io, ev_exp, ev;

   // Round-robin from cur_pid+1; cur_pid itself is checked last.
   always_comb begin
      sel   = '0;
      idx   = '0;
      found = 1'b0;
      for (int i = PROC_N; i >= 1; i--) begin
         idx = PID_W'((int'(cur_pid) + i) % PROC_N);
         if (slot_state[idx] == S_READY) begin
            sel   = idx;
            found = 1'b1;
         end
      end
   end

   assign active = fsm == F_RUN && instr_valid && pc > PC_W'(OS_PC_LIMIT);
   assign ev_end = active && proc_end;
   assign ev_io  = active && !proc_end && io_instr;
   assign ev_exp = active && !proc_end && !io_instr && ({1'b0, count} + 17'd1 >= {1'b0, quantum});
   assign ev     = ev_end || ev_io || ev_exp;

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < PROC_N; i++) begin
            slot_state[i] <= S_EMPTY;
            saved_pc[i]   <= '0;
            blk_cnt[i]    <= '0;
         end
         fsm          <= F_IDLE;
         count        <= '0;
         quantum      <= 16'(QUANTUM_DEF);
         switch_req   <= 1'b0;
         switch_cause <= 2'b00;
         next_pid     <= '0;
         next_pc      <= '0;
         cur_pid      <= '0;
         idle         <= 1'b0;
`ifdef QUANTUM_SCHEDULER_STATS_EN
         switch_cnt   <= '0;
         preempt_cnt  <= '0;
`endif
      end else begin
         for (int i = 0; i < PROC_N; i++) begin
            if (slot_state[i] == S_BLOCKED) begin
               if (blk_cnt[i] == '0) slot_state[i] <= S_READY;
               else blk_cnt[i] <= blk_cnt[i] - 1'b1;
            end
         end
         if (proc_start && slot_state[start_pid] != S_RUN) begin
            slot_state[start_pid] <= S_READY;
            saved_pc[start_pid]   <= start_pc;
         end
         if (quantum_load) quantum <= quantum_val == 16'd0 ? 16'd1 : quantum_val;
         // FSM writes come last so an ack wins over a same-cycle proc_start.
         case (fsm)
            F_IDLE: begin
               idle <= !found;
               if (found) begin
                  switch_req   <= 1'b1;
                  switch_cause <= 2'b00;
                  next_pid     <= sel;
                  next_pc      <= saved_pc[sel];
                  fsm          <= F_SWITCH;
               end
            end
            F_RUN: begin
               if (active) count <= ev ? 16'd0 : count + 16'd1;
               if (ev_end) slot_state[cur_pid] <= S_EMPTY;
               if (ev_io) begin
                  slot_state[cur_pid] <= S_BLOCKED;
                  blk_cnt[cur_pid]    <= BW'(IO_LAT - 1);
               end
               if (ev_io || (ev_exp && found)) saved_pc[cur_pid] <= pc + PC_W'(1);
               if (ev_exp && found) slot_state[cur_pid] <= S_READY;
               if (ev && found) begin
                  switch_req   <= 1'b1;
                  switch_cause <= ev_end ? 2'b11 : ev_io ? 2'b10 : 2'b01;
                  next_pid     <= sel;
                  next_pc      <= saved_pc[sel];
                  fsm          <= F_SWITCH;
               end else if (ev_end || ev_io) begin
                  idle <= 1'b1;
                  fsm  <= F_IDLE;
               end
            end
            F_SWITCH: begin
               if (switch_ack) begin
                  cur_pid              <= next_pid;
                  slot_state[next_pid] <= S_RUN;
                  count                <= '0;
                  switch_req           <= 1'b0;
                  switch_cause         <= 2'b00;
                  idle                 <= 1'b0;
                  fsm                  <= F_RUN;
`ifdef QUANTUM_SCHEDULER_STATS_EN
                  if (switch_cnt != '1) switch_cnt <= switch_cnt + 32'd1;
                  if (switch_cause == 2'b01 && preempt_cnt != '1) preempt_cnt <= preempt_cnt + 32'd1;
`endif
               end
            end
            default: fsm <= F_IDLE;
         endcase
      end
   end
endmodule
